// File: rtl/dbus_sram_responder.sv
// Data-bus SRAM responder: accepts one dBus command at a time, performs a byte/half/word access
// on a word-organised memory and returns exactly one response after a fixed latency.
module dbus_sram_responder #(
   parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
   parameter int          DEPTH_WORDS  = 1024,
   parameter int          READ_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rstf,
   input  logic        dBus_cmd_valid,
   output logic        dBus_cmd_ready,
   input  logic [31:0] dBus_cmd_payload_addr,
   input  logic [31:0] dBus_cmd_payload_data,
   input  logic [3:0]  dBus_cmd_payload_size,
   input  logic        dBus_cmd_payload_wr,
   output logic [31:0] dBus_rsp_data,
   output logic        dBus_rsp_valid,
   output logic        dBus_rsp_error
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = (READ_LATENCY > 2) ? CNT_W'(READ_LATENCY - 2) : '0;
   localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;

   localparam logic [3:0] SIZE_BYTE = 4'b0001;
   localparam logic [3:0] SIZE_HALF = 4'b0011;
   localparam logic [3:0] SIZE_WORD = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              rerr_q, rerr_d;

   logic [31:0]       mem [DEPTH_WORDS];

   logic [32:0]       offset;
   logic              in_range;
   logic [1:0]        lane;
   logic [IDX_W-1:0]  word_idx;
   logic              access_err;
   logic [3:0]        byte_en;
   logic [31:0]       wdata_shift;
   logic [31:0]       rd_word;
   logic [31:0]       rd_shift;
   logic [31:0]       rd_masked;
   logic              accept;
   logic              mem_we;

   // The 33-bit subtraction keeps addresses below the base (borrow into bit 32) from aliasing.
   always_comb begin
      offset   = {1'b0, dBus_cmd_payload_addr} - {1'b0, ADDR_BASE};
      in_range = ~offset[32] & (offset < MEM_BYTES);
      lane     = offset[1:0];
      word_idx = offset[IDX_W+1:2];

      access_err = ~in_range;
      case (dBus_cmd_payload_size)
         SIZE_BYTE: ;
         SIZE_HALF: if (lane[0])       access_err = 1'b1;
         SIZE_WORD: if (lane != 2'b00) access_err = 1'b1;
         default:   access_err = 1'b1;
      endcase

      byte_en     = dBus_cmd_payload_size << lane;
      wdata_shift = dBus_cmd_payload_data << {lane, 3'b000};

      rd_word  = mem[word_idx];
      rd_shift = rd_word >> {lane, 3'b000};
      case (dBus_cmd_payload_size)
         SIZE_BYTE: rd_masked = {24'h0, rd_shift[7:0]};
         SIZE_HALF: rd_masked = {16'h0, rd_shift[15:0]};
         default:   rd_masked = rd_shift;
      endcase

      dBus_cmd_ready = (state_q == S_IDLE) & rstf;
      accept         = dBus_cmd_ready & dBus_cmd_valid;
      mem_we         = accept & dBus_cmd_payload_wr & ~access_err;
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_shift[8*b +: 8];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      rerr_d  = rerr_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               rerr_d = access_err;
               if (dBus_cmd_payload_wr) begin
                  rdata_d = 32'h0;
                  state_d = S_RESP;
               end else begin
                  rdata_d = access_err ? 32'h0 : rd_masked;
                  if (READ_LATENCY == 1) begin
                     state_d = S_RESP;
                  end else begin
                     state_d = S_WAIT;
                     cnt_d   = CNT_LOAD;
                  end
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) state_d = S_RESP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdata_q <= 32'h0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         rerr_q  <= rerr_d;
      end
   end

   // The response register may hold a pending read; it is only exposed during the strobe.
   assign dBus_rsp_valid = (state_q == S_RESP);
   assign dBus_rsp_data  = dBus_rsp_valid ? rdata_q : 32'h0;
   assign dBus_rsp_error = dBus_rsp_valid & rerr_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Self-checking bench for dbus_sram_responder: three instances cover latencies 1, 2 and 4
// and a non-zero base address; expected responses flow through a scoreboard queue.
module tb_dbus_sram_responder;

   typedef struct {
      int          sel;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  size;
      logic [31:0] exp_data;
      logic        exp_err;
      int          lat;
   } cmd_t;

   logic        clk = 1'b0;
   logic        rstf = 1'b0;
   logic [2:0]  cmd_valid = 3'b000;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [3:0]  size = 4'h0;
   logic        wr = 1'b0;
   logic [2:0]  ready;
   logic [2:0]  rvalid;
   logic [2:0]  rerr;
   logic [31:0] rdata [3];

   int checks = 0;
   int errors = 0;
   int accepted [3] = '{0, 0, 0};
   int pulses [3] = '{0, 0, 0};
   cmd_t sb_q [$];

   always #5 clk = ~clk;

   dbus_sram_responder #(.ADDR_BASE(32'h0000_0000), .DEPTH_WORDS(1024), .READ_LATENCY(2)) u_dut0 (
      .clk(clk), .rstf(rstf), .dBus_cmd_valid(cmd_valid[0]), .dBus_cmd_ready(ready[0]),
      .dBus_cmd_payload_addr(addr), .dBus_cmd_payload_data(wdata), .dBus_cmd_payload_size(size),
      .dBus_cmd_payload_wr(wr), .dBus_rsp_data(rdata[0]), .dBus_rsp_valid(rvalid[0]),
      .dBus_rsp_error(rerr[0]));

   dbus_sram_responder #(.ADDR_BASE(32'h0000_1000), .DEPTH_WORDS(16), .READ_LATENCY(1)) u_dut1 (
      .clk(clk), .rstf(rstf), .dBus_cmd_valid(cmd_valid[1]), .dBus_cmd_ready(ready[1]),
      .dBus_cmd_payload_addr(addr), .dBus_cmd_payload_data(wdata), .dBus_cmd_payload_size(size),
      .dBus_cmd_payload_wr(wr), .dBus_rsp_data(rdata[1]), .dBus_rsp_valid(rvalid[1]),
      .dBus_rsp_error(rerr[1]));

   dbus_sram_responder #(.ADDR_BASE(32'h0000_0000), .DEPTH_WORDS(64), .READ_LATENCY(4)) u_dut2 (
      .clk(clk), .rstf(rstf), .dBus_cmd_valid(cmd_valid[2]), .dBus_cmd_ready(ready[2]),
      .dBus_cmd_payload_addr(addr), .dBus_cmd_payload_data(wdata), .dBus_cmd_payload_size(size),
      .dBus_cmd_payload_wr(wr), .dBus_rsp_data(rdata[2]), .dBus_rsp_valid(rvalid[2]),
      .dBus_rsp_error(rerr[2]));

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) if (rvalid[i] === 1'b1) pulses[i]++;
   end

   function automatic cmd_t mk(input int sel, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s,
                               input logic [31:0] ed, input logic ee, input int lat);
      cmd_t c;
      c.sel = sel; c.wr = w; c.addr = a; c.data = d; c.size = s;
      c.exp_data = ed; c.exp_err = ee; c.lat = lat;
      return c;
   endfunction

   // Drives one command through the handshake and reports when/what the DUT answered (lat=-1: none).
   task automatic run_cmd(input cmd_t c, output int lat, output logic [31:0] od, output logic oe);
      int n = 0;
      @(negedge clk);
      while (ready[c.sel] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      wr = c.wr; addr = c.addr; wdata = c.data; size = c.size;
      cmd_valid[c.sel] = 1'b1;
      @(posedge clk);
      accepted[c.sel]++;
      @(negedge clk);
      cmd_valid[c.sel] = 1'b0;
      lat = 1;
      while (rvalid[c.sel] !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (rvalid[c.sel] !== 1'b1) lat = -1;
      od = rdata[c.sel];
      oe = rerr[c.sel];
   endtask

   task automatic test_reset();
      rstf = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (ready !== 3'b000 || rvalid !== 3'b000 || rerr !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_ctrl ready=%b valid=%b err=%b required 000 000 000", ready, rvalid, rerr);
      end
      checks++;
      if (rdata[0] !== 32'h0 || rdata[1] !== 32'h0 || rdata[2] !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_data got %h %h %h required 0", rdata[0], rdata[1], rdata[2]);
      end
      rstf = 1'b1;
      @(negedge clk);
      checks++;
      if (ready !== 3'b111) begin
         errors++;
         $display("[TB] FAIL reset_release ready=%b required 111", ready);
      end
   endtask

   task automatic test_word_and_lanes();
      cmd_t cmds [$];
      cmd_t e;
      int lat;
      logic [31:0] od;
      logic oe;
      cmds.push_back(mk(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1));
      cmds.push_back(mk(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 2));
      cmds.push_back(mk(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, 1));
      cmds.push_back(mk(0, 1'b1, 32'h22, 32'hFFFFFFAA, 4'h1, 32'h0, 1'b0, 1));
      cmds.push_back(mk(0, 1'b0, 32'h20, 32'h0, 4'hF, 32'h11AA3344, 1'b0, 2));
      cmds.push_back(mk(0, 1'b0, 32'h23, 32'h0, 4'h1, 32'h00000011, 1'b0, 2));
      cmds.push_back(mk(0, 1'b0, 32'h22, 32'h0, 4'h3, 32'h000011AA, 1'b0, 2));
      cmds.push_back(mk(0, 1'b0, 32'h20, 32'h0, 4'h3, 32'h00003344, 1'b0, 2));
      foreach (cmds[i]) begin
         sb_q.push_back(cmds[i]);
         run_cmd(cmds[i], lat, od, oe);
         e = sb_q.pop_front();
         checks++;
         if (lat != e.lat || od !== e.exp_data || oe !== e.exp_err) begin
            errors++;
            $display("[TB] FAIL lanes[%0d] lat=%0d data=%h err=%b required lat=%0d data=%h err=%b",
                     i, lat, od, oe, e.lat, e.exp_data, e.exp_err);
         end
      end
   endtask

   task automatic test_errors();
      cmd_t cmds [$];
      cmd_t e;
      int lat;
      logic [31:0] od;
      logic oe;
      cmds.push_back(mk(0, 1'b0, 32'h21, 32'h0, 4'h3, 32'h0, 1'b1, 2));
      cmds.push_back(mk(0, 1'b1, 32'h12, 32'h55555555, 4'hF, 32'h0, 1'b1, 1));
      cmds.push_back(mk(0, 1'b0, 32'h1000, 32'h0, 4'hF, 32'h0, 1'b1, 2));
      cmds.push_back(mk(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h7, 32'h0, 1'b1, 1));
      cmds.push_back(mk(0, 1'b1, 32'h22, 32'h0000BBBB, 4'hF, 32'h0, 1'b1, 1));
      cmds.push_back(mk(0, 1'b0, 32'h20, 32'h0, 4'hF, 32'h11AA3344, 1'b0, 2));
      cmds.push_back(mk(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 2));
      foreach (cmds[i]) begin
         sb_q.push_back(cmds[i]);
         run_cmd(cmds[i], lat, od, oe);
         e = sb_q.pop_front();
         checks++;
         if (lat != e.lat || od !== e.exp_data || oe !== e.exp_err) begin
            errors++;
            $display("[TB] FAIL errors[%0d] lat=%0d data=%h err=%b required lat=%0d data=%h err=%b",
                     i, lat, od, oe, e.lat, e.exp_data, e.exp_err);
         end
      end
   endtask

   task automatic test_back_to_back();
      cmd_t e;
      @(negedge clk);
      wr = 1'b0; addr = 32'h10; size = 4'hF; cmd_valid[0] = 1'b1;
      sb_q.push_back(mk(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 2));
      @(posedge clk);
      accepted[0]++;
      @(negedge clk);
      addr = 32'h20;
      checks++;
      if (ready[0] !== 1'b0 || rvalid[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_wait ready=%b valid=%b required 0 0", ready[0], rvalid[0]);
      end
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (ready[0] !== 1'b0 || rvalid[0] !== 1'b1 || rdata[0] !== e.exp_data) begin
         errors++;
         $display("[TB] FAIL b2b_resp ready=%b valid=%b data=%h required 0 1 %h",
                  ready[0], rvalid[0], rdata[0], e.exp_data);
      end
      @(negedge clk);
      checks++;
      if (ready[0] !== 1'b1 || rvalid[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_idle ready=%b valid=%b required 1 0", ready[0], rvalid[0]);
      end
      sb_q.push_back(mk(0, 1'b0, 32'h20, 32'h0, 4'hF, 32'h11AA3344, 1'b0, 2));
      @(posedge clk);
      accepted[0]++;
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      checks++;
      if (rvalid[0] !== 1'b0 || ready[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_second_wait valid=%b ready=%b required 0 0", rvalid[0], ready[0]);
      end
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (rvalid[0] !== 1'b1 || rdata[0] !== e.exp_data || rerr[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_second_resp valid=%b data=%h err=%b required 1 %h 0",
                  rvalid[0], rdata[0], rerr[0], e.exp_data);
      end
   endtask

   task automatic test_latency_sweep();
      cmd_t cmds [$];
      cmd_t e;
      int lat;
      logic [31:0] od;
      logic oe;
      cmds.push_back(mk(1, 1'b1, 32'h1000, 32'h01234567, 4'hF, 32'h0, 1'b0, 1));
      cmds.push_back(mk(1, 1'b0, 32'h1000, 32'h0, 4'hF, 32'h01234567, 1'b0, 1));
      cmds.push_back(mk(1, 1'b1, 32'h103F, 32'h0000005A, 4'h1, 32'h0, 1'b0, 1));
      cmds.push_back(mk(1, 1'b0, 32'h103F, 32'h0, 4'h1, 32'h0000005A, 1'b0, 1));
      cmds.push_back(mk(1, 1'b0, 32'h1040, 32'h0, 4'hF, 32'h0, 1'b1, 1));
      cmds.push_back(mk(1, 1'b0, 32'h0FFC, 32'h0, 4'hF, 32'h0, 1'b1, 1));
      cmds.push_back(mk(1, 1'b0, 32'hFFFFFFFC, 32'h0, 4'hF, 32'h0, 1'b1, 1));
      cmds.push_back(mk(1, 1'b1, 32'h0000_0000, 32'h77777777, 4'hF, 32'h0, 1'b1, 1));
      cmds.push_back(mk(2, 1'b1, 32'h08, 32'hA5A50F0F, 4'hF, 32'h0, 1'b0, 1));
      cmds.push_back(mk(2, 1'b0, 32'h0A, 32'h0, 4'h3, 32'h0000A5A5, 1'b0, 4));
      cmds.push_back(mk(2, 1'b0, 32'h09, 32'h0, 4'h1, 32'h0000000F, 1'b0, 4));
      cmds.push_back(mk(2, 1'b0, 32'h100, 32'h0, 4'h1, 32'h0, 1'b1, 4));
      foreach (cmds[i]) begin
         sb_q.push_back(cmds[i]);
         run_cmd(cmds[i], lat, od, oe);
         e = sb_q.pop_front();
         checks++;
         if (lat != e.lat || od !== e.exp_data || oe !== e.exp_err) begin
            errors++;
            $display("[TB] FAIL latency[%0d] lat=%0d data=%h err=%b required lat=%0d data=%h err=%b",
                     i, lat, od, oe, e.lat, e.exp_data, e.exp_err);
         end
      end
   endtask

   task automatic test_reset_mid_read();
      cmd_t cmds [$];
      cmd_t e;
      int lat;
      logic [31:0] od;
      logic oe;
      int bad = 0;
      e = mk(2, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1);
      sb_q.push_back(e);
      run_cmd(e, lat, od, oe);
      e = sb_q.pop_front();
      checks++;
      if (lat != e.lat || oe !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rst_write lat=%0d err=%b required lat=1 err=0", lat, oe);
      end
      // Abandoned read: accepted but never answered, so it is not counted as accepted.
      @(negedge clk);
      wr = 1'b0; addr = 32'h40; size = 4'hF; cmd_valid[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid[2] = 1'b0;
      rstf = 1'b0;
      #1;
      checks++;
      if (rvalid !== 3'b000 || ready !== 3'b000 || rdata[2] !== 32'h0 || rerr[2] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rst_mid valid=%b ready=%b data=%h err=%b required 000 000 0 0",
                  rvalid, ready, rdata[2], rerr[2]);
      end
      repeat (2) @(negedge clk);
      rstf = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (rvalid[2] !== 1'b0 || ready[2] !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL rst_after bad_cycles=%0d required 0", bad);
      end
      cmds.push_back(mk(2, 1'b0, 32'h40, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 4));
      cmds.push_back(mk(0, 1'b0, 32'h20, 32'h0, 4'hF, 32'h11AA3344, 1'b0, 2));
      cmds.push_back(mk(1, 1'b0, 32'h1000, 32'h0, 4'hF, 32'h01234567, 1'b0, 1));
      foreach (cmds[i]) begin
         sb_q.push_back(cmds[i]);
         run_cmd(cmds[i], lat, od, oe);
         e = sb_q.pop_front();
         checks++;
         if (lat != e.lat || od !== e.exp_data || oe !== e.exp_err) begin
            errors++;
            $display("[TB] FAIL rst_retained[%0d] lat=%0d data=%h err=%b required lat=%0d data=%h err=%b",
                     i, lat, od, oe, e.lat, e.exp_data, e.exp_err);
         end
      end
   endtask

   task automatic test_random_lanes();
      logic [31:0] model [8];
      cmd_t c;
      cmd_t e;
      int lat;
      logic [31:0] od;
      logic oe;
      int w, kind, ln;
      for (int i = 0; i < 8; i++) begin
         model[i] = $urandom;
         c = mk(0, 1'b1, 32'h300 + 32'(4*i), model[i], 4'hF, 32'h0, 1'b0, 1);
         sb_q.push_back(c);
         run_cmd(c, lat, od, oe);
         e = sb_q.pop_front();
         checks++;
         if (lat != e.lat || oe !== e.exp_err) begin
            errors++;
            $display("[TB] FAIL rand_init[%0d] lat=%0d err=%b required lat=1 err=0", i, lat, oe);
         end
      end
      for (int i = 0; i < 24; i++) begin
         w    = int'($urandom_range(0, 7));
         kind = int'($urandom_range(0, 2));
         ln   = (kind == 0) ? int'($urandom_range(0, 3)) : (kind == 1) ? 2 * int'($urandom_range(0, 1)) : 0;
         c = mk(0, 1'($urandom_range(0, 1)), 32'h300 + 32'(4*w + ln), $urandom,
                (kind == 0) ? 4'h1 : (kind == 1) ? 4'h3 : 4'hF, 32'h0, 1'b0, 1);
         if (c.wr) begin
            if (kind == 0)      model[w][8*ln +: 8]  = c.data[7:0];
            else if (kind == 1) model[w][8*ln +: 16] = c.data[15:0];
            else                model[w]             = c.data;
         end else begin
            c.lat = 2;
            if (kind == 0)      c.exp_data = {24'h0, model[w][8*ln +: 8]};
            else if (kind == 1) c.exp_data = {16'h0, model[w][8*ln +: 16]};
            else                c.exp_data = model[w];
         end
         sb_q.push_back(c);
         run_cmd(c, lat, od, oe);
         e = sb_q.pop_front();
         checks++;
         if (lat != e.lat || od !== e.exp_data || oe !== e.exp_err) begin
            errors++;
            $display("[TB] FAIL rand[%0d] addr=%h lat=%0d data=%h err=%b required lat=%0d data=%h err=%b",
                     i, e.addr, lat, od, oe, e.lat, e.exp_data, e.exp_err);
         end
      end
   endtask

   task automatic test_pulse_count();
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (pulses[i] != accepted[i]) begin
            errors++;
            $display("[TB] FAIL pulse_count[%0d] responses=%0d required %0d", i, pulses[i], accepted[i]);
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_word_and_lanes();
      test_errors();
      test_back_to_back();
      test_latency_sweep();
      test_reset_mid_read();
      test_random_lanes();
      test_pulse_count();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
